// File: rtl/program_loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// program_loader_pkg : shared state encoding and frame constants for the loader
// Revision: 1.0
// ----------------------------------------------------------------------------
package program_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WR    = 3'd4,
    S_CHECK = 3'd5,
    S_RUN   = 3'd6,
    S_FAIL  = 3'd7
  } state_t;

  localparam int WORD_BYTES = 2;
  localparam int MAX_WORDS  = 256;

endpackage
`default_nettype wire

// File: rtl/loader_checksum.sv
`default_nettype none
// ----------------------------------------------------------------------------
// loader_checksum : 8-bit XOR accumulator; clear together with en loads din
// Revision: 1.0
// ----------------------------------------------------------------------------
module loader_checksum (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] csum
);

  logic [7:0] r_acc;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_acc <= 8'h00;
    end else if (clear) begin
      r_acc <= en ? din : 8'h00;
    end else if (en) begin
      r_acc <= r_acc ^ din;
    end
  end

  assign csum = r_acc;

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// program_loader : byte-stream boot loader writing a checksummed image to RAM
// Revision: 1.0
// ----------------------------------------------------------------------------
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 16,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic [7:0]        RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DIN,
  output logic              CPU_NCLR,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [8:0]        WORDS_LOADED
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [7:0]        r_hi;
  logic [8:0]        r_remaining;
  logic [8:0]        r_words;
  logic [7:0]        w_csum;
  logic              w_rx_ready;
  logic              w_accept;
  logic              w_csum_en;

  assign w_rx_ready = (r_state == S_COUNT) || (r_state == S_HI) ||
                      (r_state == S_LO)    || (r_state == S_CHECK);
  // A START in the same cycle as a byte drops that byte.
  assign w_accept   = RX_VALID & w_rx_ready & ~START;
  assign w_csum_en  = w_accept & (r_state != S_CHECK);

  loader_checksum u_checksum (
    .CLK   (CLK),
    .CLR   (CLR),
    .clear (START | (r_state == S_COUNT)),
    .en    (w_csum_en),
    .din   (RX_DATA),
    .csum  (w_csum)
  );

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (START) begin
      w_state_nxt = S_COUNT;
    end else begin
      case (r_state)
        S_COUNT: if (w_accept) w_state_nxt = S_HI;
        S_HI:    if (w_accept) w_state_nxt = S_LO;
        S_LO:    if (w_accept) w_state_nxt = S_WR;
        S_WR:    w_state_nxt = (r_remaining == 9'd1) ? S_CHECK : S_HI;
        S_CHECK: if (w_accept) w_state_nxt = (RX_DATA == w_csum) ? S_RUN : S_FAIL;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_addr      <= START_ADDR;
      r_din       <= '0;
      r_hi        <= 8'h00;
      r_remaining <= 9'd0;
      r_words     <= 9'd0;
    end else if (START) begin
      r_words <= 9'd0;
    end else begin
      case (r_state)
        S_COUNT: if (w_accept) begin
          r_remaining <= (RX_DATA == 8'h00) ? 9'(MAX_WORDS) : {1'b0, RX_DATA};
          r_addr      <= START_ADDR;
        end
        S_HI: if (w_accept) r_hi <= RX_DATA;
        S_LO: if (w_accept) r_din <= DATA_W'({r_hi, RX_DATA});
        S_WR: begin
          // Address wraps modulo the RAM depth.
          r_addr      <= r_addr + ADDR_W'(1);
          r_words     <= r_words + 9'd1;
          r_remaining <= r_remaining - 9'd1;
        end
        default: ;
      endcase
    end
  end

  assign RX_READY     = w_rx_ready;
  assign MEM_WE       = (r_state == S_WR);
  assign MEM_ADDR     = r_addr;
  assign MEM_DIN      = r_din;
  assign CPU_NCLR     = (r_state == S_RUN);
  assign DONE         = (r_state == S_RUN);
  assign ERR          = (r_state == S_FAIL);
  assign BUSY         = w_rx_ready | (r_state == S_WR);
  assign WORDS_LOADED = r_words;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_program_loader : randomized frame-level checks of program_loader
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_program_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       START;
  logic [7:0] RX_DATA;
  logic       RX_VALID;

  logic        a_rdy, a_we, a_nclr, a_busy, a_done, a_err;
  logic [7:0]  a_addr;
  logic [15:0] a_din;
  logic [8:0]  a_words;
  logic        b_rdy, b_we, b_nclr, b_busy, b_done, b_err;
  logic [7:0]  b_addr;
  logic [15:0] b_din;
  logic [8:0]  b_words;

  int checks = 0;
  int errors = 0;
  wr_t qa[$];
  wr_t qb[$];

  always #5 CLK = ~CLK;

  program_loader u_dut_a (
    .CLK(CLK), .CLR(CLR), .START(START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_READY(a_rdy), .MEM_WE(a_we), .MEM_ADDR(a_addr), .MEM_DIN(a_din),
    .CPU_NCLR(a_nclr), .BUSY(a_busy), .DONE(a_done), .ERR(a_err),
    .WORDS_LOADED(a_words)
  );

  program_loader #(.START_ADDR(8'h10)) u_dut_b (
    .CLK(CLK), .CLR(CLR), .START(START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_READY(b_rdy), .MEM_WE(b_we), .MEM_ADDR(b_addr), .MEM_DIN(b_din),
    .CPU_NCLR(b_nclr), .BUSY(b_busy), .DONE(b_done), .ERR(b_err),
    .WORDS_LOADED(b_words)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // RAM write scoreboard plus write-enable invariants
  always @(negedge CLK) begin
    if (a_we) qa.push_back('{a_addr, a_din});
    if (b_we) qb.push_back('{b_addr, b_din});
    if (!CLR) begin
      check_val("we_outside_busy", {31'd0, a_we & ~a_busy}, 0);
      check_val("we_with_ready", {31'd0, a_we & a_rdy}, 0);
      check_val("nclr_without_done", {31'd0, b_nclr & ~b_done}, 0);
    end
  end

  task automatic check_reset();
    check_val("rst_ready", {31'd0, a_rdy}, 0);
    check_val("rst_we", {31'd0, a_we}, 0);
    check_val("rst_addr_a", {24'd0, a_addr}, 32'h00);
    check_val("rst_addr_b", {24'd0, b_addr}, 32'h10);
    check_val("rst_din", {16'd0, a_din}, 0);
    check_val("rst_nclr", {31'd0, a_nclr}, 0);
    check_val("rst_busy", {31'd0, a_busy}, 0);
    check_val("rst_done", {31'd0, a_done}, 0);
    check_val("rst_err", {31'd0, a_err}, 0);
    check_val("rst_words", {23'd0, a_words}, 0);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    bit ok = 1'b0;
    repeat ($urandom_range(0, max_gap)) begin
      RX_DATA = 8'($urandom);
      RX_VALID = 1'b0;
      @(negedge CLK);
    end
    RX_DATA  = b;
    RX_VALID = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (a_rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check_val("rx_ready_seen", {31'd0, ok}, 1);
    if (ok) @(negedge CLK);
    RX_VALID = 1'b0;
  endtask

  task automatic stall_check(input int cycles, input int words_so_far);
    RX_VALID = 1'b0;
    repeat (cycles) begin
      @(negedge CLK);
      check_val("stall_ready", {31'd0, a_rdy}, 1);
      check_val("stall_busy", {31'd0, a_busy}, 1);
      check_val("stall_we", {31'd0, a_we}, 0);
      check_val("stall_words", {23'd0, a_words}, words_so_far);
    end
  endtask

  // Frame-level model: N words of {HI,LO}; good iff CHK equals XOR of N and all data.
  task automatic send_frame(input logic [7:0] n, input logic [7:0] data[$],
                            input logic [7:0] chk, input int max_gap,
                            input int stall_after, input bit do_start);
    int         words = (n == 8'd0) ? 256 : int'(n);
    logic [7:0] cs = n;
    bit         good;
    foreach (data[i]) cs ^= data[i];
    good = (chk == cs);
    qa.delete();
    qb.delete();
    if (do_start) pulse_start();
    send_byte(n, max_gap);
    for (int i = 0; i < 2 * words; i++) begin
      send_byte(data[i], max_gap);
      if (i == stall_after) stall_check(5, i / 2);
    end
    send_byte(chk, max_gap);
    check_val("end_done", {31'd0, a_done}, {31'd0, good});
    check_val("end_err", {31'd0, a_err}, {31'd0, !good});
    check_val("end_nclr", {31'd0, a_nclr}, {31'd0, good});
    check_val("end_busy", {31'd0, a_busy}, 0);
    check_val("end_ready", {31'd0, a_rdy}, 0);
    check_val("end_words", {23'd0, a_words}, words);
    check_val("end_err_b", {31'd0, b_err}, {31'd0, !good});
    check_val("n_writes_a", qa.size(), words);
    check_val("n_writes_b", qb.size(), words);
    for (int i = 0; i < words && i < qa.size() && i < qb.size(); i++) begin
      check_val("wr_addr_a", {24'd0, qa[i].addr}, (i + 32'h00) & 32'hFF);
      check_val("wr_addr_b", {24'd0, qb[i].addr}, (i + 32'h10) & 32'hFF);
      check_val("wr_data_a", {16'd0, qa[i].data}, {16'd0, data[2*i], data[2*i+1]});
      check_val("wr_data_b", {16'd0, qb[i].data}, {16'd0, data[2*i], data[2*i+1]});
    end
  endtask

  task automatic random_frame(input int n, input bit good, input int max_gap);
    logic [7:0] data[$];
    logic [7:0] cs = 8'(n);
    int         words = (n == 0) ? 256 : n;
    for (int i = 0; i < 2 * words; i++) begin
      data.push_back(8'($urandom));
      cs ^= data[i];
    end
    if (!good) cs ^= 8'(1 << $urandom_range(0, 7));
    send_frame(8'(n), data, cs, max_gap, -1, 1'b1);
  endtask

  initial begin
    logic [7:0] d[$];
    CLR = 1'b1; START = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
    repeat (3) @(negedge CLK);
    check_reset();
    CLR = 1'b0;
    @(negedge CLK);
    check_val("idle_ready", {31'd0, a_rdy}, 0);
    check_val("idle_nclr", {31'd0, a_nclr}, 0);

    d = '{8'h00, 8'h05, 8'h40, 8'h03};
    send_frame(8'd2, d, 8'h44, 0, -1, 1'b1);
    send_frame(8'd2, d, 8'h45, 1, -1, 1'b1);

    // START in RUN clears DONE and releases nothing
    d = '{8'h12, 8'h34};
    send_frame(8'd1, d, 8'h01 ^ 8'h12 ^ 8'h34, 0, -1, 1'b1);
    pulse_start();
    check_val("restart_nclr", {31'd0, a_nclr}, 0);
    check_val("restart_done", {31'd0, a_done}, 0);
    check_val("restart_busy", {31'd0, a_busy}, 1);
    d = '{8'hAB, 8'hCD, 8'h9A, 8'h0F, 8'h77, 8'h31};
    send_frame(8'd3, d, 8'h03 ^ 8'hAB ^ 8'hCD ^ 8'h9A ^ 8'h0F ^ 8'h77 ^ 8'h31, 0, 0, 1'b0);

    // restart mid-word, with a byte offered in the START cycle
    qa.delete();
    pulse_start();
    send_byte(8'd3, 0);
    send_byte(8'hAA, 0);
    RX_DATA = 8'h55; RX_VALID = 1'b1; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; RX_VALID = 1'b0;
    check_val("mid_restart_ready", {31'd0, a_rdy}, 1);
    check_val("mid_restart_words", {23'd0, a_words}, 0);
    check_val("mid_restart_no_write", qa.size(), 0);
    d = '{8'h5E, 8'hC1};
    send_frame(8'd1, d, 8'h01 ^ 8'h5E ^ 8'hC1, 0, -1, 1'b0);

    // CLR mid-load
    pulse_start();
    send_byte(8'd4, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    CLR = 1'b1;
    @(negedge CLK);
    check_reset();
    CLR = 1'b0;
    @(negedge CLK);

    random_frame(0, 1'b1, 0);
    for (int f = 0; f < 8; f++) begin
      random_frame($urandom_range(1, 12), ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader. Writes a program image into the system's 16-bit x 256 RAM, then releases the CPU from reset.
- It is the writer end of the RAM port that the CPU fetch path reads. Its memory outputs drive the RAM through a loader/CPU arbitration mux that sits outside this block.
- It owns the CPU's active-low clear, so the CPU runs only after a complete image has passed its checksum.

Parameters:
- ADDR_W, 8, RAM address width (256 words).
- DATA_W, 16, RAM word width. Fixed at 2 bytes: instruction byte first, then data byte.
- START_ADDR, 8'h00, first RAM address written.

Ports:
- CLK  in  1  system clock.
- CLR  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a new load from any state.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA is valid.
- RX_READY  out  1  loader accepts a byte this cycle.
- MEM_WE  out  1  RAM write enable, one-cycle pulse.
- MEM_ADDR  out  ADDR_W  RAM address.
- MEM_DIN  out  DATA_W  RAM write data.
- CPU_NCLR  out  1  active-low CPU clear; 1 lets the CPU run.
- BUSY  out  1  a load is in progress.
- DONE  out  1  the image loaded and its checksum matched.
- ERR  out  1  checksum mismatch.
- WORDS_LOADED  out  9  count of words written in the current load.

Behaviour:
- Reset (CLR=1 at a CLK edge) forces state IDLE and these output values:
  - RX_READY=0, MEM_WE=0, MEM_ADDR=START_ADDR, MEM_DIN=0;
  - CPU_NCLR=0, BUSY=0, DONE=0, ERR=0, WORDS_LOADED=0.
- CLR takes priority over START and over any pending byte.
- A byte transfer completes on a CLK edge where RX_VALID & RX_READY. RX_READY is combinational from state only, never from RX_VALID.
- Frame format:
  - COUNT byte N; N=0 means 256 words.
  - N word pairs, each sent as HI byte then LO byte.
  - CHK byte, equal to the XOR of N and all 2N data bytes.
- States and transitions:
  - IDLE: RX_READY=0. START -> COUNT.
  - COUNT: RX_READY=1. On accept: remaining <= (N==0 ? 256 : N), csum <= N, addr <= START_ADDR, go HI.
  - HI: RX_READY=1. On accept: hi_reg <= byte, csum ^= byte, go LO.
  - LO: RX_READY=1. On accept: MEM_DIN <= {hi_reg, byte}, csum ^= byte, go WR.
  - WR: RX_READY=0, MEM_WE=1 for exactly one cycle with MEM_ADDR=addr.
    - Next edge: addr <= addr+1 (mod 2^ADDR_W, wraps 255->0), WORDS_LOADED+1, remaining-1.
    - Go CHECK if remaining was 1, else HI.
  - CHECK: RX_READY=1. On accept: byte==csum -> RUN, else -> FAIL.
  - RUN: DONE=1, CPU_NCLR=1. No bytes accepted.
  - FAIL: ERR=1, CPU_NCLR=0. No bytes accepted.
- BUSY=1 in COUNT, HI, LO, WR and CHECK.
- CPU_NCLR=1 only in RUN.
  - It rises on the edge entering RUN.
  - The system's NCLR sync flop adds one more cycle before the CPU leaves clear.
- START from any non-reset state restarts a load, including mid-frame and from RUN or FAIL:
  - next state COUNT;
  - CPU_NCLR=0, DONE=0, ERR=0, WORDS_LOADED=0;
  - a partially assembled word is discarded and not written.
- START and a byte accept in the same cycle: START wins, and that byte is dropped.
- Words already written before a restart or a FAIL stay in RAM; the loader does not erase them.
- MEM_ADDR holds its value outside WR. MEM_WE is never asserted outside WR.
- Throughput: at most one word per 3 cycles (HI, LO, WR).

Decomposition:
- Shared package holds:
  - the state enum (IDLE, COUNT, HI, LO, WR, CHECK, RUN, FAIL);
  - the constants WORD_BYTES=2 and MAX_WORDS=256.
- One natural sub-module, loader_checksum: an 8-bit XOR accumulator with clear and enable.
- The remainder is a single FSM with its datapath registers.

Test Plan:
- Load 2 words with N=2, bytes 0x00 0x05, 0x40 0x03, CHK=0x02^0x00^0x05^0x40^0x03=0x44:
  - RAM[0]=0x0005, RAM[1]=0x4003, 2 MEM_WE pulses;
  - then DONE=1, CPU_NCLR=1, WORDS_LOADED=2.
- Same frame with CHK=0x45: both words written, then ERR=1, DONE=0, CPU_NCLR stays 0.
- N=0 with START_ADDR=0x10: 256 words written, addresses wrap from 0xFF to 0x00 and end at 0x0F; WORDS_LOADED=256.
- Drive RX_VALID=0 for 5 cycles between HI and LO: state and outputs hold, no MEM_WE, then load completes normally.
- Pulse START after the first HI byte of word 1 (N=3):
  - word 1 is not written, FSM returns to COUNT;
  - a fresh 1-word frame loads at START_ADDR;
  - asserting CLR mid-load instead returns all outputs to reset values within 1 cycle.
- Raise START in RUN: CPU_NCLR falls the next cycle and DONE clears.
